// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer: isolates, drains, resets and clears a subordinate after a guard timeout.
// Optional cause capture is enabled by defining SLV_GUARD_RST_CAUSE_EN.
module slv_guard_rst_ctrl #(
    parameter int CntWidth   = 10,
    parameter int MaxRetries = 3,
    parameter int FltWidth   = $clog2(MaxRetries + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                guard_ena_i,
    input  logic                timeout_wr_i,
    input  logic                timeout_rd_i,
    input  logic                sub_idle_i,
    input  logic [CntWidth-1:0] drain_budget_i,
    input  logic [CntWidth-1:0] rst_hold_i,
    input  logic                rst_stat_i,
    input  logic                irq_clr_i,
    input  logic                unlock_i,
    output logic                isolate_o,
    output logic                rst_req_o,
    output logic                clear_o,
    output logic                irq_o,
    output logic                busy_o,
    output logic                locked_o,
    output logic [FltWidth-1:0] fault_cnt_o,
    output logic [1:0]          cause_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RESET   = 3'd2,
        ST_RECOVER = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_LOCKED  = 3'd5
    } state_e;

    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [FltWidth-1:0] FltMax  = FltWidth'(MaxRetries);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth-1:0] cnt_nxt_s;
    logic [FltWidth-1:0] fault_cnt_r;
    logic [FltWidth-1:0] fault_nxt_s;
    logic                fault_entry_s;
    logic                isolate_r;
    logic                rst_req_r;
    logic                clear_r;
    logic                irq_r;
    logic                busy_r;
    logic                locked_r;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        sat_inc = (v == CntMax) ? v : v + CntWidth'(1);
    endfunction

    // Next-state, cycle counter and fault counter logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        fault_nxt_s   = fault_cnt_r;
        fault_entry_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (guard_ena_i && (timeout_wr_i || timeout_rd_i)) begin
                    state_nxt_s   = ST_DRAIN;
                    cnt_nxt_s     = CntZero;
                    fault_entry_s = 1'b1;
                    fault_nxt_s   = (fault_cnt_r == FltMax) ? fault_cnt_r
                                                            : fault_cnt_r + FltWidth'(1);
                end else begin
                    cnt_nxt_s = CntZero;
                end
            end
            ST_DRAIN: begin
                if (sub_idle_i || (cnt_r == drain_budget_i)) begin
                    state_nxt_s = ST_RESET;
                    cnt_nxt_s   = CntZero;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_RESET: begin
                // The hold time must elapse before the reset status is trusted.
                if ((cnt_r >= rst_hold_i) && rst_stat_i) begin
                    state_nxt_s = ST_RECOVER;
                    cnt_nxt_s   = CntZero;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_RECOVER: begin
                if (!rst_stat_i) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RECOVER;
                end
            end
            ST_CLEAR: begin
                if (fault_cnt_r == FltMax) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (unlock_i) begin
                    state_nxt_s = ST_IDLE;
                    fault_nxt_s = {FltWidth{1'b0}};
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CntZero;
            end
        endcase
    end

    // State, counters and outputs registered together from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CntZero;
            fault_cnt_r <= {FltWidth{1'b0}};
            isolate_r   <= 1'b0;
            rst_req_r   <= 1'b0;
            clear_r     <= 1'b0;
            irq_r       <= 1'b0;
            busy_r      <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            fault_cnt_r <= fault_nxt_s;
            isolate_r   <= (state_nxt_s != ST_IDLE);
            rst_req_r   <= (state_nxt_s == ST_RESET);
            clear_r     <= (state_nxt_s == ST_CLEAR);
            busy_r      <= (state_nxt_s != ST_IDLE);
            locked_r    <= (state_nxt_s == ST_LOCKED);
            // A new fault wins over a simultaneous clear.
            if (fault_entry_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr_i) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign isolate_o   = isolate_r;
    assign rst_req_o   = rst_req_r;
    assign clear_o     = clear_r;
    assign irq_o       = irq_r;
    assign busy_o      = busy_r;
    assign locked_o    = locked_r;
    assign fault_cnt_o = fault_cnt_r;

`ifdef SLV_GUARD_RST_CAUSE_EN
    logic [1:0] cause_r;

    // Cause of the most recent fault, held until the next fault or an unlock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cause_r <= 2'b00;
        end else if (fault_entry_s) begin
            cause_r <= {timeout_rd_i, timeout_wr_i};
        end else if ((state_r == ST_LOCKED) && unlock_i) begin
            cause_r <= 2'b00;
        end else begin
            cause_r <= cause_r;
        end
    end

    assign cause_o = cause_r;
`else
    assign cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Self-checking bench for slv_guard_rst_ctrl: directed episode table, hand sequences, random episodes.
// Expected timelines are derived from phase durations (drain, reset hold, recover) computed arithmetically.
module tb_slv_guard_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       guard_ena = 1'b0;
    logic       timeout_wr = 1'b0;
    logic       timeout_rd = 1'b0;
    logic       sub_idle = 1'b0;
    logic [9:0] drain_budget = 10'd0;
    logic [9:0] rst_hold = 10'd0;
    logic       rst_stat = 1'b0;
    logic       irq_clr = 1'b0;
    logic       unlock = 1'b0;
    logic       isolate;
    logic       rst_req;
    logic       clear;
    logic       irq;
    logic       busy;
    logic       locked;
    logic [1:0] fault_cnt;
    logic [1:0] cause;

    int checks = 0;
    int errors = 0;

    // model of the architecturally visible counters
    logic [1:0] fault_m = 2'd0;
    logic       irq_m = 1'b0;
    logic [1:0] cause_m = 2'b00;

    typedef struct {
        bit wr; bit rd;
        int b;  int d;  int h;  int s;  int f;
        bit clr0;
        int ld; int lr; int lrec;
    } vec_t;

    vec_t tbl [4];

    slv_guard_rst_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .guard_ena_i    (guard_ena),
        .timeout_wr_i   (timeout_wr),
        .timeout_rd_i   (timeout_rd),
        .sub_idle_i     (sub_idle),
        .drain_budget_i (drain_budget),
        .rst_hold_i     (rst_hold),
        .rst_stat_i     (rst_stat),
        .irq_clr_i      (irq_clr),
        .unlock_i       (unlock),
        .isolate_o      (isolate),
        .rst_req_o      (rst_req),
        .clear_o        (clear),
        .irq_o          (irq),
        .busy_o         (busy),
        .locked_o       (locked),
        .fault_cnt_o    (fault_cnt),
        .cause_o        (cause)
    );

    always #5 clk = ~clk;

    // {isolate, rst_req, clear, irq, busy, locked, fault_cnt, cause}
    function automatic logic [9:0] exp_vec(input bit iso, input bit rq, input bit clr,
                                           input bit bsy, input bit lck);
        exp_vec = {iso, rq, clr, irq_m, bsy, lck, fault_m, cause_m};
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {isolate, rst_req, clear, irq, busy, locked, fault_cnt, cause};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (iso,req,clr,irq,busy,lck,fcnt,cause) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fault_cause(input bit rd, input bit wr);
`ifdef SLV_GUARD_RST_CAUSE_EN
        fault_cause = {rd, wr};
`else
        fault_cause = 2'b00;
`endif
    endfunction

    // One full recovery episode; ld/lr/lrec are the expected DRAIN/RESET/RECOVER lengths.
    task automatic episode(input string name, input bit wr, input bit rd,
                           input int b, input int d, input int h, input int s, input int f,
                           input int ld, input int lr, input int lrec,
                           input bit clr0, input bit rnd);
        int r0;
        int c0;
        int q;
        r0 = ld;
        c0 = r0 + lr;
        q  = c0 + lrec;
        drain_budget = 10'(b);
        rst_hold     = 10'(h);
        for (int j = 0; j <= q + 1; j++) begin
            if (j == 0) begin
                guard_ena  = 1'b1;
                timeout_wr = wr;
                timeout_rd = rd;
                irq_clr    = clr0;
            end else begin
                guard_ena  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                timeout_wr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                timeout_rd = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                irq_clr    = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
            end
            sub_idle = (j >= d + 1);
            rst_stat = (j >= r0 + s + 1) && (j <= c0 + f);
            if (j == 0) begin
                fault_m = (fault_m == 2'd3) ? fault_m : fault_m + 2'd1;
                irq_m   = 1'b1;
                cause_m = fault_cause(rd, wr);
            end else if (irq_clr) begin
                irq_m = 1'b0;
            end
            step();
            if (j < r0)
                check({name, "_drain"}, exp_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
            else if (j < c0)
                check({name, "_reset"}, exp_vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
            else if (j < q)
                check({name, "_recover"}, exp_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
            else if (j == q)
                check({name, "_clear"}, exp_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
            else if (fault_m == 2'd3)
                check({name, "_locked"}, exp_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
            else
                check({name, "_idle"}, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        timeout_wr = 1'b0;
        timeout_rd = 1'b0;
        irq_clr    = 1'b0;
        sub_idle   = 1'b0;
        rst_stat   = 1'b0;
        guard_ena  = 1'b1;
    endtask

    // Idle cycles: timeouts only while disabled, so nothing may start.
    task automatic idle_cycles(input string name, input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            guard_ena  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            timeout_wr = guard_ena ? 1'b0 : 1'($urandom_range(0, 1));
            timeout_rd = guard_ena ? 1'b0 : 1'($urandom_range(0, 1));
            irq_clr    = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (irq_clr) irq_m = 1'b0;
            step();
            check(name, exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        timeout_wr = 1'b0;
        timeout_rd = 1'b0;
        irq_clr    = 1'b0;
        guard_ena  = 1'b1;
    endtask

    // Stay LOCKED under noisy timeouts, then unlock.
    task automatic locked_phase(input int n);
        for (int i = 0; i < n; i++) begin
            guard_ena  = 1'($urandom_range(0, 1));
            timeout_wr = 1'($urandom_range(0, 1));
            timeout_rd = 1'($urandom_range(0, 1));
            irq_clr    = ($urandom_range(0, 3) == 0);
            if (irq_clr) irq_m = 1'b0;
            step();
            check("locked_hold", exp_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        timeout_wr = 1'b0;
        timeout_rd = 1'b0;
        irq_clr    = 1'b0;
        unlock     = 1'b1;
        fault_m    = 2'd0;
        cause_m    = 2'b00;
        step();
        check("unlock_idle", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        unlock    = 1'b0;
        guard_ena = 1'b1;
    endtask

    initial begin
        tbl[0] = '{wr: 1'b1, rd: 1'b0, b: 5, d: 0,  h: 4,  s: 2, f: 1, clr0: 1'b0, ld: 1, lr: 5,  lrec: 2};
        tbl[1] = '{wr: 1'b0, rd: 1'b1, b: 5, d: 15, h: 0,  s: 0, f: 0, clr0: 1'b1, ld: 6, lr: 1,  lrec: 1};
        tbl[2] = '{wr: 1'b1, rd: 1'b1, b: 0, d: 3,  h: 2,  s: 6, f: 3, clr0: 1'b0, ld: 1, lr: 7,  lrec: 4};
        tbl[3] = '{wr: 1'b1, rd: 1'b0, b: 7, d: 2,  h: 10, s: 0, f: 0, clr0: 1'b0, ld: 3, lr: 11, lrec: 1};

        #3;
        check("reset_hold", 10'b0);
        #9;
        rst_n = 1'b1;
        step();
        check("after_reset", 10'b0);

        // Disabled guard with a persistent write timeout must never start a sequence.
        guard_ena  = 1'b0;
        timeout_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("ena_low", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        timeout_wr = 1'b0;
        guard_ena  = 1'b1;

        for (int k = 0; k < 4; k++) begin
            episode($sformatf("tbl%0d", k), tbl[k].wr, tbl[k].rd, tbl[k].b, tbl[k].d,
                    tbl[k].h, tbl[k].s, tbl[k].f, tbl[k].ld, tbl[k].lr, tbl[k].lrec,
                    tbl[k].clr0, 1'b0);
            if (fault_m == 2'd3) locked_phase(5);
            idle_cycles("tbl_gap", 2, 1'b0);
        end

        // irq clears on request while idle.
        irq_clr = 1'b1;
        irq_m   = 1'b0;
        step();
        check("irq_clr_idle", exp_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        irq_clr = 1'b0;

        // Asynchronous reset while the reset request is active.
        begin
            bit reached;
            reached      = 1'b0;
            drain_budget = 10'd3;
            rst_hold     = 10'd10;
            sub_idle     = 1'b1;
            rst_stat     = 1'b0;
            timeout_wr   = 1'b1;
            for (int i = 0; i < 10 && !reached; i++) begin
                step();
                timeout_wr = 1'b0;
                if (rst_req) reached = 1'b1;
            end
            checks++;
            if (!reached) begin
                errors++;
                $display("FAIL rst_req_reach: got 0 expected rst_req within 10 cycles");
            end
            #2;
            rst_n = 1'b0;
            #1;
            fault_m = 2'd0;
            irq_m   = 1'b0;
            cause_m = 2'b00;
            check("async_reset", 10'b0);
            @(negedge clk);
            @(negedge clk);
            sub_idle = 1'b0;
            rst_n    = 1'b1;
            step();
            check("post_async_reset", 10'b0);
        end

        // Random episodes checked against the duration model.
        for (int e = 0; e < 16; e++) begin
            int b; int d; int h; int s; int f;
            bit wr; bit rd;
            b = $urandom_range(0, 7);
            d = $urandom_range(0, 9);
            h = $urandom_range(0, 6);
            s = $urandom_range(0, 8);
            f = $urandom_range(0, 5);
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            episode($sformatf("rnd%0d", e), wr, rd, b, d, h, s, f,
                    ((d < b) ? d : b) + 1, ((h > s) ? h : s) + 1, f + 1,
                    1'($urandom_range(0, 1)), 1'b1);
            if (fault_m == 2'd3) locked_phase($urandom_range(1, 6));
            idle_cycles("rnd_gap", $urandom_range(1, 4), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
